mul_seq_ctrl: RTL and testbench

//  Sequences the shared iterative shift-add multiplier behind the ALU for MUL
//  (ALU control code 4'b0011). Detects a MUL in EX, stalls the pipeline while the

---
 rtl/mul_seq_ctrl_if.sv | 24 ++
 rtl/mul_seq_ctrl.sv | 88 ++++++++
 tb/tb_mul_seq_ctrl.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/mul_seq_ctrl_if.sv
// EX-stage hookup of the MUL sequencer: operands and control from the pipeline,
// and the stall/result returned to it.
interface mul_seq_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             valid_i;
  logic [3:0]       ALUCtrl_i;
  logic [WIDTH-1:0] src1_i;
  logic [WIDTH-1:0] src2_i;
  logic             flush_i;
  logic             stall_o;
  logic [WIDTH-1:0] result_o;
  logic             result_valid_o;

  modport master (
    output valid_i, ALUCtrl_i, src1_i, src2_i, flush_i,
    input  stall_o, result_o, result_valid_o
  );

  modport slave (
    input  valid_i, ALUCtrl_i, src1_i, src2_i, flush_i,
    output stall_o, result_o, result_valid_o
  );
endinterface

// File: rtl/mul_seq_ctrl.sv
// Iterative shift-add MUL sequencer: stalls the pipeline one cycle per multiplier
// bit, then presents the low WIDTH product bits for a single cycle.
module mul_seq_ctrl #(
  parameter int WIDTH      = 32,
  parameter bit EARLY_TERM = 1'b1
) (
  input  logic           clk_i,
  input  logic           rst_i,
  mul_seq_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  localparam logic [3:0]    ALU_MUL  = 4'b0011;
  localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplr;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_result;
  logic             r_result_valid;

  logic             w_start;
  logic             w_last;
  logic [WIDTH-1:0] w_acc_nxt;

  // Gated by reset so stall is forced low while reset is held, even with a MUL in EX.
  assign w_start   = rst_i & bus.valid_i & (bus.ALUCtrl_i == ALU_MUL) & ~bus.flush_i;
  assign w_acc_nxt = r_mplr[0] ? (r_acc + r_mcand) : r_acc;
  assign w_last    = (r_cnt == CNT_LAST) ||
                     (EARLY_TERM && (r_mplr[WIDTH-1:1] == '0));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state        <= S_IDLE;
      r_acc          <= '0;
      r_mcand        <= '0;
      r_mplr         <= '0;
      r_cnt          <= '0;
      r_result       <= '0;
      r_result_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_result_valid <= 1'b0;
          if (w_start) begin
            r_mcand <= bus.src1_i;
            r_mplr  <= bus.src2_i;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_state <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (bus.flush_i) begin
            r_state <= S_IDLE;
          end else begin
            r_acc   <= w_acc_nxt;
            r_mcand <= r_mcand << 1;
            r_mplr  <= r_mplr >> 1;
            r_cnt   <= r_cnt + 1'b1;
            if (w_last) begin
              r_state        <= S_DONE;
              r_result       <= w_acc_nxt;
              r_result_valid <= 1'b1;
            end
          end
        end
        S_DONE: begin
          r_state        <= S_IDLE;
          r_result_valid <= 1'b0;
        end
        default: begin
          r_state        <= S_IDLE;
          r_result_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.stall_o        = (r_state == S_BUSY) | ((r_state == S_IDLE) & w_start);
  assign bus.result_o       = r_result;
  assign bus.result_valid_o = r_result_valid;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Self-checking bench for mul_seq_ctrl: one instance per EARLY_TERM setting,
// driven from shared stimulus and checked against a cycle-level product model.
module tb_mul_seq_ctrl;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          v, fl;
  logic [3:0]    op;
  logic [W-1:0]  s1, s2;

  mul_seq_ctrl_if #(.WIDTH(W)) if0 ();
  mul_seq_ctrl_if #(.WIDTH(W)) if1 ();

  assign if0.valid_i = v;  assign if0.ALUCtrl_i = op;
  assign if0.src1_i  = s1; assign if0.src2_i    = s2; assign if0.flush_i = fl;
  assign if1.valid_i = v;  assign if1.ALUCtrl_i = op;
  assign if1.src1_i  = s1; assign if1.src2_i    = s2; assign if1.flush_i = fl;

  mul_seq_ctrl #(.WIDTH(W), .EARLY_TERM(1'b0)) u_et0 (
    .clk_i(clk), .rst_i(rst_n), .bus(if0.slave)
  );
  mul_seq_ctrl #(.WIDTH(W), .EARLY_TERM(1'b1)) u_et1 (
    .clk_i(clk), .rst_i(rst_n), .bus(if1.slave)
  );

  logic         st  [2];
  logic         rv  [2];
  logic [W-1:0] res [2];
  assign st[0] = if0.stall_o;  assign rv[0] = if0.result_valid_o; assign res[0] = if0.result_o;
  assign st[1] = if1.stall_o;  assign rv[1] = if1.result_valid_o; assign res[1] = if1.result_o;

  int tests = 0;
  int fails = 0;
  logic [W-1:0] prev [2];

  task automatic chk(input string name, input int d, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s (et%0d) at %0t: got %h expected %h", name, d, $time, act, exp);
    end
  endtask

  // Iterations from the spec rule: WIDTH, or highest set multiplier bit + 1 (min 1).
  function automatic int n_iter(input logic [W-1:0] b, input bit et);
    int n;
    if (!et) return W;
    n = 1;
    for (int i = 0; i < W; i++) if (b[i]) n = i + 1;
    return n;
  endfunction

  task automatic do_mul(input logic [W-1:0] a, input logic [W-1:0] b, input int fc);
    int n [2];
    bit ab [2];
    logic [W-1:0] prod;
    longint unsigned p64;
    p64  = longint'(a) * longint'(b);
    prod = p64[W-1:0];
    for (int d = 0; d < 2; d++) begin
      n[d]  = n_iter(b, d == 1);
      ab[d] = (fc != 0) && (fc <= n[d]);
    end
    v = 1'b1; op = 4'b0011; s1 = a; s2 = b; fl = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("start_stall", d, W'(st[d]), W'(1));
      chk("start_rv", d, W'(rv[d]), W'(0));
    end
    @(posedge clk); #1;
    for (int c = 1; c <= W + 2; c++) begin
      v = 1'b0; op = 4'($urandom); s1 = $urandom; s2 = $urandom; fl = (c == fc);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        bit exp_st, exp_rv;
        logic [W-1:0] exp_res;
        exp_st  = (c <= n[d]) && !((fc != 0) && (fc < c));
        exp_rv  = (c == n[d] + 1) && !ab[d];
        exp_res = (!ab[d] && c >= n[d] + 1) ? prod : prev[d];
        chk("stall", d, W'(st[d]), W'(exp_st));
        chk("rvalid", d, W'(rv[d]), W'(exp_rv));
        chk("result", d, res[d], exp_res);
      end
      @(posedge clk); #1;
    end
    fl = 1'b0;
    for (int d = 0; d < 2; d++) if (!ab[d]) prev[d] = prod;
  endtask

  typedef struct {
    logic         v;
    logic [3:0]   op;
    logic [W-1:0] a, b;
    logic         f;
    logic         st0, st1, rv1;
    logic [W-1:0] res1;
  } vec_t;

  function automatic vec_t mk(input logic vv, input logic [3:0] o, input logic [W-1:0] a,
                              input logic [W-1:0] b, input logic f, input logic st0,
                              input logic st1, input logic rv1, input logic [W-1:0] r1);
    vec_t t;
    t.v = vv; t.op = o; t.a = a; t.b = b; t.f = f;
    t.st0 = st0; t.st1 = st1; t.rv1 = rv1; t.res1 = r1;
    return t;
  endfunction

  vec_t tbl [18];

  initial begin
    // Back-to-back 6*7 then 2*9 on the early-terminating unit, then non-MUL ops,
    // an invalid MUL, and a MUL flushed in IDLE (which also aborts the et0 unit).
    for (int i = 0; i <= 3; i++) tbl[i] = mk(1, 4'h3, 6, 7, 0, 1, 1, 0, 0);
    tbl[4]  = mk(1, 4'h3, 6, 7, 0, 1, 0, 1, 42);
    for (int i = 5; i <= 9; i++) tbl[i] = mk(1, 4'h3, 2, 9, 0, 1, 1, 0, 42);
    tbl[10] = mk(1, 4'h3, 2, 9, 0, 1, 0, 1, 18);
    tbl[11] = mk(1, 4'h2, 5, 5, 0, 1, 0, 0, 18);
    tbl[12] = mk(1, 4'h6, 5, 5, 0, 1, 0, 0, 18);
    tbl[13] = mk(1, 4'h1, 5, 5, 0, 1, 0, 0, 18);
    tbl[14] = mk(0, 4'h3, 5, 5, 0, 1, 0, 0, 18);
    tbl[15] = mk(1, 4'h3, 5, 5, 1, 1, 0, 0, 18);
    tbl[16] = mk(0, 4'h0, 0, 0, 0, 0, 0, 0, 18);
    tbl[17] = mk(0, 4'h0, 0, 0, 0, 0, 0, 0, 18);

    v = 1'b0; op = '0; s1 = '0; s2 = '0; fl = 1'b0;
    rst_n = 1'b0;
    #3;
    for (int d = 0; d < 2; d++) begin
      chk("rst_stall", d, W'(st[d]), W'(0));
      chk("rst_rv", d, W'(rv[d]), W'(0));
      chk("rst_result", d, res[d], W'(0));
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      v = tbl[i].v; op = tbl[i].op; s1 = tbl[i].a; s2 = tbl[i].b; fl = tbl[i].f;
      @(negedge clk);
      chk("tbl_stall", 0, W'(st[0]), W'(tbl[i].st0));
      chk("tbl_rv", 0, W'(rv[0]), W'(0));
      chk("tbl_result", 0, res[0], W'(0));
      chk("tbl_stall", 1, W'(st[1]), W'(tbl[i].st1));
      chk("tbl_rv", 1, W'(rv[1]), W'(tbl[i].rv1));
      chk("tbl_result", 1, res[1], tbl[i].res1);
      @(posedge clk); #1;
    end
    prev[0] = '0; prev[1] = 32'd18;

    // Asynchronous reset in the middle of a busy MUL, with the MUL still presented.
    v = 1'b1; op = 4'h3; s1 = '1; s2 = '1; fl = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) chk("busy_before_rst", d, W'(st[d]), W'(1));
    #1 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("arst_stall", d, W'(st[d]), W'(0));
      chk("arst_rv", d, W'(rv[d]), W'(0));
      chk("arst_result", d, res[d], W'(0));
    end
    v = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    prev[0] = '0; prev[1] = '0;

    do_mul(32'd3, 32'd5, 0);
    do_mul(32'd7, 32'd0, 0);
    do_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    do_mul(32'h0001_0000, 32'h0001_0000, 0);
    do_mul(32'd123, 32'h0000_F0F0, 5);
    do_mul(32'd9, 32'd3, 3);

    for (int k = 0; k < 25; k++) begin
      logic [W-1:0] a, b;
      int fc;
      a  = $urandom;
      b  = $urandom >> $urandom_range(0, 31);
      fc = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, W + 2)) : 0;
      do_mul(a, b, fc);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
